// File: rtl/vliw_hazard_fwd_unit_if.sv
// Bundle-level hazard/forwarding interface between pipeline control and the hazard unit.
// With VLIW_HAZARD_STATS_EN defined it also carries the stall statistics counters.
interface vliw_hazard_fwd_unit_if #(
  parameter int SLOTS  = 2,
  parameter int SRCS   = 2,
  parameter int REG_AW = 5
);
  localparam int FWD_W = $clog2(2*SLOTS+1);

  logic [SLOTS*SRCS*REG_AW-1:0] p0_rs;
  logic [SLOTS-1:0]             p0_wr;
  logic [SLOTS*REG_AW-1:0]      p0_rd;
  logic [SLOTS-1:0]             p0_mc;
  logic [SLOTS-1:0]             p2_regwr;
  logic [SLOTS*REG_AW-1:0]      p2_rd;
  logic [SLOTS-1:0]             p2_load;
  logic [SLOTS-1:0]             p3_regwr;
  logic [SLOTS*REG_AW-1:0]      p3_rd;
  logic [SLOTS-1:0]             mc_issue_vld;
  logic [SLOTS*SRCS*FWD_W-1:0]  fwd;
  logic                         stall;
  logic                         mc_full;
`ifdef VLIW_HAZARD_STATS_EN
  logic [31:0]                  stall_cnt;
  logic [31:0]                  ldu_cnt;
`endif

  modport master (
    output p0_rs, p0_wr, p0_rd, p0_mc, p2_regwr, p2_rd, p2_load,
           p3_regwr, p3_rd, mc_issue_vld,
`ifdef VLIW_HAZARD_STATS_EN
    input  stall_cnt, ldu_cnt,
`endif
    input  fwd, stall, mc_full
  );

  modport slave (
    input  p0_rs, p0_wr, p0_rd, p0_mc, p2_regwr, p2_rd, p2_load,
           p3_regwr, p3_rd, mc_issue_vld,
`ifdef VLIW_HAZARD_STATS_EN
    output stall_cnt, ldu_cnt,
`endif
    output fwd, stall, mc_full
  );
endinterface

// File: rtl/vliw_hazard_fwd_unit.sv
// Per-operand forwarding select, load-use detection and multi-cycle countdown scoreboard.
// Optional VLIW_HAZARD_STATS_EN adds saturating stall_cnt / ldu_cnt counters.
module vliw_hazard_fwd_unit #(
  parameter int SLOTS    = 2,
  parameter int SRCS     = 2,
  parameter int REG_AW   = 5,
  parameter int MC_DEPTH = 4,
  parameter int MC_LAT   = 3
) (
  input logic                    clk,
  input logic                    rst_n,
  vliw_hazard_fwd_unit_if.slave  bus
);
  localparam int FWD_W = $clog2(2*SLOTS+1);
  localparam int CW    = $clog2(MC_LAT+1);
  localparam int NOPS  = SLOTS*SRCS;

  logic [MC_DEPTH-1:0] r_vld;
  logic [REG_AW-1:0]   r_rd  [MC_DEPTH];
  logic [CW-1:0]       r_cnt [MC_DEPTH];

  logic [MC_DEPTH-1:0] w_vld_n;
  logic [REG_AW-1:0]   w_rd_n  [MC_DEPTH];
  logic [CW-1:0]       w_cnt_n [MC_DEPTH];
  logic [MC_DEPTH-1:0] w_retire;
  logic [SLOTS-1:0]    w_alloc;
  logic                w_done;

  logic [NOPS*FWD_W-1:0] w_fwd;
  logic [REG_AW-1:0]     w_rs;
  logic                  w_hit2, w_ld2, w_hit3, w_ldu, w_sb_hit, w_cap;
  int                    w_sel2, w_sel3, w_free_next;

  always_comb begin
    for (int s = 0; s < SLOTS; s++)
      w_alloc[s] = bus.mc_issue_vld[s] & bus.p2_regwr[s] & (bus.p2_rd[s*REG_AW +: REG_AW] != '0);
  end

  // Retirement is applied first so a retiring entry is reusable on the same edge.
  always_comb begin
    w_vld_n  = r_vld;
    w_rd_n   = r_rd;
    w_cnt_n  = r_cnt;
    w_retire = '0;
    w_done   = 1'b0;
    for (int e = 0; e < MC_DEPTH; e++) begin
      if (r_vld[e]) begin
        if (r_cnt[e] == CW'(1)) begin
          w_retire[e] = 1'b1;
          w_vld_n[e]  = 1'b0;
        end else begin
          w_cnt_n[e] = r_cnt[e] - CW'(1);
        end
      end
    end
    for (int s = 0; s < SLOTS; s++) begin
      w_done = 1'b0;
      if (w_alloc[s]) begin
        for (int e = 0; e < MC_DEPTH; e++) begin
          if (!w_done && !w_vld_n[e]) begin
            w_vld_n[e] = 1'b1;
            w_rd_n[e]  = bus.p2_rd[s*REG_AW +: REG_AW];
            w_cnt_n[e] = CW'(MC_LAT);
            w_done     = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int e = 0; e < MC_DEPTH; e++) begin
        r_rd[e]  <= '0;
        r_cnt[e] <= '0;
      end
    end else begin
      r_vld <= w_vld_n;
      for (int e = 0; e < MC_DEPTH; e++) begin
        r_rd[e]  <= w_rd_n[e];
        r_cnt[e] <= w_cnt_n[e];
      end
    end
  end

  // p2 beats p3; within a stage the last (highest) matching slot wins.
  always_comb begin
    w_fwd  = '0;
    w_ldu  = 1'b0;
    w_rs   = '0;
    w_hit2 = 1'b0;
    w_ld2  = 1'b0;
    w_hit3 = 1'b0;
    w_sel2 = 0;
    w_sel3 = 0;
    for (int o = 0; o < NOPS; o++) begin
      w_rs   = bus.p0_rs[o*REG_AW +: REG_AW];
      w_hit2 = 1'b0;
      w_ld2  = 1'b0;
      w_hit3 = 1'b0;
      w_sel2 = 0;
      w_sel3 = 0;
      for (int k = 0; k < SLOTS; k++) begin
        if (w_rs != '0 && bus.p2_regwr[k] && bus.p2_rd[k*REG_AW +: REG_AW] == w_rs) begin
          w_hit2 = 1'b1;
          w_sel2 = k;
          w_ld2  = bus.p2_load[k];
        end
        if (w_rs != '0 && bus.p3_regwr[k] && bus.p3_rd[k*REG_AW +: REG_AW] == w_rs) begin
          w_hit3 = 1'b1;
          w_sel3 = k;
        end
      end
      if (w_hit2) begin
        if (w_ld2) w_ldu = 1'b1;
        else       w_fwd[o*FWD_W +: FWD_W] = FWD_W'(1 + w_sel2);
      end else if (w_hit3) begin
        w_fwd[o*FWD_W +: FWD_W] = FWD_W'(1 + SLOTS + w_sel3);
      end
    end
  end

  always_comb begin
    w_sb_hit = 1'b0;
    for (int e = 0; e < MC_DEPTH; e++) begin
      if (r_vld[e]) begin
        for (int o = 0; o < NOPS; o++)
          if (bus.p0_rs[o*REG_AW +: REG_AW] == r_rd[e]) w_sb_hit = 1'b1;
        for (int s = 0; s < SLOTS; s++)
          if (bus.p0_wr[s] && bus.p0_rd[s*REG_AW +: REG_AW] == r_rd[e]) w_sb_hit = 1'b1;
      end
    end
    w_free_next = $countones(~r_vld) + $countones(w_retire) - $countones(w_alloc);
    w_cap       = (bus.p0_mc != '0) && (w_free_next < $countones(bus.p0_mc));
  end

  assign bus.fwd     = w_fwd;
  assign bus.stall   = rst_n & (w_ldu | w_sb_hit | w_cap);
  assign bus.mc_full = rst_n & (&r_vld);

`ifdef VLIW_HAZARD_STATS_EN
  logic [31:0] r_stall_cnt, r_ldu_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_ldu_cnt   <= '0;
    end else begin
      if (bus.stall && r_stall_cnt != 32'hFFFF_FFFF) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_ldu && r_ldu_cnt != 32'hFFFF_FFFF)       r_ldu_cnt   <= r_ldu_cnt + 32'd1;
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
  assign bus.ldu_cnt   = r_ldu_cnt;
`endif
endmodule

// File: tb/tb_vliw_hazard_fwd_unit.sv
// Directed bench for vliw_hazard_fwd_unit at default parameters (SLOTS=2, SRCS=2, MC_LAT=3).
module tb_vliw_hazard_fwd_unit;
  localparam int FWD_W = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  vliw_hazard_fwd_unit_if #(.SLOTS(2), .SRCS(2), .REG_AW(5)) bus ();

  vliw_hazard_fwd_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.p0_rs        = '0;
    bus.p0_wr        = '0;
    bus.p0_rd        = '0;
    bus.p0_mc        = '0;
    bus.p2_regwr     = '0;
    bus.p2_rd        = '0;
    bus.p2_load      = '0;
    bus.p3_regwr     = '0;
    bus.p3_rd        = '0;
    bus.mc_issue_vld = '0;
  endtask

  task automatic set_rs(input int s, input int j, input logic [4:0] r);
    bus.p0_rs[(s*2+j)*5 +: 5] = r;
  endtask

  function automatic logic [FWD_W-1:0] fwd_of(input int op);
    return bus.fwd[op*FWD_W +: FWD_W];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    cyc();
    cyc();
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%0b exp=0", bus.stall); end
    checks++; if (bus.mc_full !== 1'b0) begin errors++; $display("FAIL reset_mc_full got=%0b exp=0", bus.mc_full); end
    rst_n = 1'b1;
    cyc();
    #1;
    for (int o = 0; o < 4; o++) begin
      checks++; if (fwd_of(o) !== 3'd0) begin errors++; $display("FAIL reset_fwd op%0d got=%0d exp=0", o, fwd_of(o)); end
    end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL post_reset_stall got=%0b exp=0", bus.stall); end
  endtask

  task automatic test_priority();
    cyc();
    idle();
    bus.p2_regwr[1] = 1'b1; bus.p2_rd[9:5] = 5'd5;
    bus.p3_regwr[0] = 1'b1; bus.p3_rd[4:0] = 5'd5;
    set_rs(0, 0, 5'd5);
    set_rs(1, 1, 5'd6);
    #1;
    checks++; if (fwd_of(0) !== 3'd2) begin errors++; $display("FAIL p2_over_p3 got=%0d exp=2", fwd_of(0)); end
    checks++; if (fwd_of(3) !== 3'd0) begin errors++; $display("FAIL no_match got=%0d exp=0", fwd_of(3)); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL priority_stall got=%0b exp=0", bus.stall); end
    // p3 only: slot0 and slot1 both write r6 -> slot1 (select 4); r5 only slot0 in p3 -> 3
    cyc();
    idle();
    bus.p3_regwr = 2'b11; bus.p3_rd = {5'd6, 5'd6};
    set_rs(1, 1, 5'd6);
    #1;
    checks++; if (fwd_of(3) !== 3'd4) begin errors++; $display("FAIL p3_high_slot got=%0d exp=4", fwd_of(3)); end
    bus.p3_rd = {5'd6, 5'd5};
    set_rs(0, 1, 5'd5);
    #1;
    checks++; if (fwd_of(1) !== 3'd3) begin errors++; $display("FAIL p3_slot0 got=%0d exp=3", fwd_of(1)); end
  endtask

  task automatic test_slot_order();
    cyc();
    idle();
    bus.p2_regwr = 2'b11; bus.p2_rd = {5'd7, 5'd7};
    set_rs(1, 0, 5'd7);
    #1;
    checks++; if (fwd_of(2) !== 3'd2) begin errors++; $display("FAIL p2_high_slot got=%0d exp=2", fwd_of(2)); end
    bus.p2_rd = '0;
    set_rs(1, 0, 5'd0);
    #1;
    checks++; if (fwd_of(2) !== 3'd0) begin errors++; $display("FAIL r0_no_fwd got=%0d exp=0", fwd_of(2)); end
  endtask

  task automatic test_load_use();
    cyc();
    idle();
    bus.p2_regwr[0] = 1'b1; bus.p2_load[0] = 1'b1; bus.p2_rd[4:0] = 5'd3;
    set_rs(1, 1, 5'd3);
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL load_use_stall got=%0b exp=1", bus.stall); end
    cyc();
    idle();
    bus.p3_regwr[0] = 1'b1; bus.p3_rd[4:0] = 5'd3;
    set_rs(1, 1, 5'd3);
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL load_in_p3_stall got=%0b exp=0", bus.stall); end
    checks++; if (fwd_of(3) !== 3'd3) begin errors++; $display("FAIL load_in_p3_fwd got=%0d exp=3", fwd_of(3)); end
    // Load in p2 hides an older p3 producer of the same register
    bus.p2_regwr[0] = 1'b1; bus.p2_load[0] = 1'b1; bus.p2_rd[4:0] = 5'd3;
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL load_hides_p3 got=%0b exp=1", bus.stall); end
  endtask

  task automatic test_mc_raw_waw(input bit waw);
    cyc();
    idle();
    bus.p2_regwr[0] = 1'b1; bus.p2_rd[4:0] = 5'd9; bus.mc_issue_vld[0] = 1'b1;
    if (!waw) set_rs(0, 0, 5'd9);
    else begin bus.p0_wr[1] = 1'b1; bus.p0_rd[9:5] = 5'd9; end
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL mc_pre_alloc waw=%0d got=%0b exp=0", waw, bus.stall); end
    for (int i = 0; i < 4; i++) begin
      cyc();
      bus.p2_regwr = '0; bus.p2_rd = '0; bus.mc_issue_vld = '0;
      #1;
      checks++;
      if (bus.stall !== (i < 3)) begin
        errors++; $display("FAIL mc_stall waw=%0d cyc=N+%0d got=%0b exp=%0b", waw, i, bus.stall, (i < 3));
      end
    end
  endtask

  task automatic test_full_and_reset();
    cyc();
    idle();
    bus.p2_regwr = 2'b11; bus.mc_issue_vld = 2'b11; bus.p2_rd = {5'd11, 5'd10};
    #1;
    checks++; if (bus.mc_full !== 1'b0) begin errors++; $display("FAIL full_empty got=%0b exp=0", bus.mc_full); end
    cyc();
    bus.p2_rd = {5'd13, 5'd12};
    #1;
    checks++; if (bus.mc_full !== 1'b0) begin errors++; $display("FAIL full_half got=%0b exp=0", bus.mc_full); end
    cyc();
    idle();
    bus.p0_mc[0] = 1'b1;
    #1;
    checks++; if (bus.mc_full !== 1'b1) begin errors++; $display("FAIL full_set got=%0b exp=1", bus.mc_full); end
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL cap_stall got=%0b exp=1", bus.stall); end
    cyc();
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL cap_release got=%0b exp=0", bus.stall); end
    checks++; if (bus.mc_full !== 1'b1) begin errors++; $display("FAIL full_still got=%0b exp=1", bus.mc_full); end
    cyc();
    #1;
    checks++; if (bus.mc_full !== 1'b0) begin errors++; $display("FAIL full_clear got=%0b exp=0", bus.mc_full); end
    cyc();
    idle();
    bus.p2_regwr[1] = 1'b1; bus.mc_issue_vld[1] = 1'b1; bus.p2_rd[9:5] = 5'd9;
    cyc();
    idle();
    set_rs(1, 0, 5'd9);
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL pre_reset_stall got=%0b exp=1", bus.stall); end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL mid_reset_stall got=%0b exp=0", bus.stall); end
    checks++; if (bus.mc_full !== 1'b0) begin errors++; $display("FAIL mid_reset_full got=%0b exp=0", bus.mc_full); end
  endtask

`ifdef VLIW_HAZARD_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0;
    idle();
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      bus.p2_regwr[1] = 1'b1; bus.p2_load[1] = 1'b1; bus.p2_rd[9:5] = 5'd4;
      set_rs(0, 1, 5'd4);
      cyc();
    end
    idle();
    bus.p2_regwr[0] = 1'b1; bus.mc_issue_vld[0] = 1'b1; bus.p2_rd[4:0] = 5'd20;
    cyc();
    idle();
    set_rs(0, 0, 5'd20);
    cyc();
    cyc();
    idle();
    #1;
    checks++; if (bus.stall_cnt !== 32'd5) begin errors++; $display("FAIL stall_cnt got=%0d exp=5", bus.stall_cnt); end
    checks++; if (bus.ldu_cnt !== 32'd3) begin errors++; $display("FAIL ldu_cnt got=%0d exp=3", bus.ldu_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_priority();
    test_slot_order();
    test_load_use();
    test_mc_raw_waw(1'b0);
    test_mc_raw_waw(1'b1);
    test_full_and_reset();
`ifdef VLIW_HAZARD_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
